rs232_uart_rx: RTL and testbench

//   Receives RS232/UART serial frames on the rx pin: 8N1 format (1 start bit, 8 data bits
//   LSB first, 1 stop bit, no parity), idle high. Outputs each good byte with a one-cycle

---
 rtl/rs232_uart_rx_if.sv | 29 ++
 rtl/rs232_uart_rx.sv | 139 +++++++++++++
 tb/tb_rs232_uart_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rs232_uart_rx_if.sv
// rtl/rs232_uart_rx_if.sv - serial line and received-byte signals of the UART receiver
interface rs232_uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic       rxLEDout;

    // Receiver side: takes the pin, produces the byte stream and status.
    modport slave (
        input  rx,
        output data_out,
        output data_valid,
        output frame_err,
        output busy,
        output rxLEDout
    );

    // User side: drives the pin, consumes the byte stream and status.
    modport master (
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy,
        input  rxLEDout
    );
endinterface

// File: rtl/rs232_uart_rx.sv
// rtl/rs232_uart_rx.sv - 8N1 UART receiver with stop-bit error and break handling
module rs232_uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic           clk,
    input  logic           rst,
    rs232_uart_rx_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_meta_q, rx_sync_q;

    // Two-flop synchroniser for the asynchronous pin; idles high so reset looks like a quiet line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // State, counters, shift register and output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Next-state logic: the counter free-runs within a state and is cleared on every transition,
    // so each state times its own interval from zero.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_sync_q) begin
                    state_d = S_START;
                end
            end

            // Re-check the line at mid start bit to reject short glitches.
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end

            // Whole-bit steps from the mid start point land each sample mid-bit.
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            // Stop sampled mid-bit; the remaining half bit lets a back-to-back start be caught in IDLE.
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end

            // A line held low after a bad stop is one event: wait for it to return high.
            S_BREAK: begin
                cnt_d = '0;
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.rxLEDout   = rx_sync_q;
endmodule

// File: tb/tb_rs232_uart_rx.sv
// tb/tb_rs232_uart_rx.sv - self-checking bench for rs232_uart_rx
module tb_rs232_uart_rx;
    localparam int CPB = 16;

    typedef struct {
        string      name;
        logic [7:0] data;
        int         p_even;
        int         p_odd;
        int         gap;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_dout;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs232_uart_rx_if u_if ();

    rs232_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int checks      = 0;
    int errors      = 0;
    int valid_cnt   = 0;
    int err_cnt     = 0;
    int overlap_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    vec_t vt[8];

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.data_valid) begin
                valid_cnt++;
                rx_q.push_back(u_if.data_out);
            end
            if (u_if.frame_err) err_cnt++;
            if (u_if.data_valid && u_if.frame_err) overlap_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives the first nbits of a frame (start, 8 data LSB first, stop); even/odd bits use separate periods.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int p_even, input int p_odd, input int nbits);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            u_if.rx = bits[k];
            repeat ((k % 2 == 0) ? p_even : p_odd) @(negedge clk);
        end
    endtask

    initial begin
        int v0, e0, n, jit, gap, low_busy0;
        logic [7:0] d, prev;

        vt[0] = '{"t1_55",      8'h55, 16, 16, 40, 1, 0, 8'h55};
        vt[1] = '{"t1_00",      8'h00, 16, 16, 40, 1, 0, 8'h00};
        vt[2] = '{"t1_ff",      8'hFF, 16, 16, 40, 1, 0, 8'hFF};
        vt[3] = '{"t2_a3",      8'hA3, 16, 16,  0, 1, 0, 8'hA3};
        vt[4] = '{"t2_3c",      8'h3C, 16, 16, 40, 1, 0, 8'h3C};
        vt[5] = '{"t6_c6_1517", 8'hC6, 15, 17, 40, 1, 0, 8'hC6};
        vt[6] = '{"t6_c6_1715", 8'hC6, 17, 15, 40, 1, 0, 8'hC6};
        vt[7] = '{"t1_e7",      8'hE7, 16, 16, 40, 1, 0, 8'hE7};

        // Reset state
        u_if.rx = 1'b1;
        rst = 1'b1;
        idle(3);
        chk("rst_data_out", u_if.data_out, 0);
        chk("rst_valid", u_if.data_valid, 0);
        chk("rst_ferr", u_if.frame_err, 0);
        chk("rst_busy", u_if.busy, 0);
        chk("rst_led", u_if.rxLEDout, 1);
        rst = 1'b0;
        idle(10);

        // Directed frames from the table
        for (int i = 0; i < 8; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(vt[i].data, 1'b1, vt[i].p_even, vt[i].p_odd, 10);
            idle(vt[i].gap);
            chk({vt[i].name, "_valid"}, valid_cnt - v0, vt[i].exp_valid);
            chk({vt[i].name, "_ferr"}, err_cnt - e0, vt[i].exp_err);
            chk({vt[i].name, "_dout"}, u_if.data_out, vt[i].exp_dout);
        end

        // Randomised stream against the byte-queue model
        rx_q.delete();
        exp_q.delete();
        e0 = err_cnt;
        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom);
            jit = $urandom_range(0, 2);
            gap = $urandom_range(0, 12);
            if (jit == 0)      send_frame(d, 1'b1, 16, 16, 10);
            else if (jit == 1) send_frame(d, 1'b1, 15, 17, 10);
            else               send_frame(d, 1'b1, 17, 15, 10);
            exp_q.push_back(d);
            idle(gap);
        end
        idle(40);
        chk("rand_count", rx_q.size(), exp_q.size());
        chk("rand_ferr", err_cnt - e0, 0);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("rand_byte%0d", i), rx_q[i], exp_q[i]);
        prev = exp_q[exp_q.size() - 1];

        // Glitch: 5 clk low, plus synchroniser lag on the LED output
        v0 = valid_cnt;
        e0 = err_cnt;
        u_if.rx = 1'b0;
        idle(1);
        chk("led_lag1", u_if.rxLEDout, 1);
        idle(1);
        chk("led_lag2", u_if.rxLEDout, 0);
        idle(3);
        u_if.rx = 1'b1;
        n = 0;
        while (u_if.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("glitch_busy_clear", u_if.busy, 0);
        idle(40);
        chk("glitch_valid", valid_cnt - v0, 0);
        chk("glitch_ferr", err_cnt - e0, 0);

        // Bad stop bit followed by a held-low line
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h5A, 1'b0, 16, 16, 10);
        low_busy0 = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!u_if.busy) low_busy0++;
        end
        chk("brk_busy_low", low_busy0, 0);
        chk("brk_ferr", err_cnt - e0, 1);
        chk("brk_valid", valid_cnt - v0, 0);
        chk("brk_dout", u_if.data_out, prev);
        u_if.rx = 1'b1;
        n = 0;
        while (u_if.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("brk_busy_clear", u_if.busy, 0);
        idle(30);
        chk("brk_ferr_once", err_cnt - e0, 1);

        // Reset during data bit 4, then a clean frame
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h00, 1'b1, 16, 16, 5);
        u_if.rx = 1'b0;
        idle(8);
        rst = 1'b1;
        u_if.rx = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_dout", u_if.data_out, 0);
        chk("mid_rst_valid", u_if.data_valid, 0);
        chk("mid_rst_ferr", u_if.frame_err, 0);
        chk("mid_rst_busy", u_if.busy, 0);
        chk("mid_rst_led", u_if.rxLEDout, 1);
        idle(200);
        chk("mid_rst_nopulse", (valid_cnt - v0) + (err_cnt - e0), 0);
        send_frame(8'h81, 1'b1, 16, 16, 10);
        idle(40);
        chk("mid_rst_81_valid", valid_cnt - v0, 1);
        chk("mid_rst_81_dout", u_if.data_out, 8'h81);
        chk("mid_rst_81_ferr", err_cnt - e0, 0);

        chk("no_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
